req_priority_arbiter: RTL and testbench
=======================================

Name: req_priority_arbiter

Overview:
- Arbitrates one shared resource among N requesters; grants exactly one requester at a time.
- Selection is fixed-priority (index 0 highest) or round-robin, chosen by parameter.
- Grant is held while the winner keeps its request high, bounded by a hold timeout.
- Sits in front of any shared datapath unit; gnt_code drives that unit's select or mux.

Parameters:
N, 8, number of requesters; power of 2, range 2..16.
CW, 3, grant code width; must equal log2(N).
RR_MODE, 0, 0 = fixed priority (lowest index wins), 1 = round-robin.
MAX_HOLD, 16, maximum consecutive grant cycles per winner; range 2..255.

Ports:
clk  in  1  rising-edge clock.
rst_n  in  1  asynchronous active-low reset.
req  in  N  request vector; requester i holds req[i] high while it wants or uses the resource.
gnt  out  N  one-hot grant, registered.
gnt_code  out  CW  binary index of granted requester; 0 when gnt_valid=0.
gnt_valid  out  1  high when any grant is active.
timeout  out  1  one-cycle pulse when a grant is force-released by MAX_HOLD.

Behaviour:
- Reset (async assert, sync release): gnt=0, gnt_code=0, gnt_valid=0, timeout=0, state=IDLE, hold_cnt=0, mask=0, rr_ptr=0.
- Eligible vector: elig = req & ~mask.
- Arbitration is combinational on elig; all outputs are registered.
- Latency: a request seen eligible at edge k in IDLE is granted (gnt valid) after edge k, i.e. one cycle.
- States:
  - IDLE: if elig!=0, pick winner w, set gnt=1<<w, gnt_code=w, gnt_valid=1, hold_cnt=1, go BUSY. Otherwise stay in IDLE with outputs 0.
  - BUSY, normal release: if req[w]=0, clear gnt, gnt_valid and gnt_code, go GAP.
  - BUSY, timeout: else if hold_cnt==MAX_HOLD, clear grant, set mask[w]=1, pulse timeout=1, go GAP.
  - BUSY, continue: otherwise hold_cnt+1 and keep the grant unchanged.
  - GAP: one mandatory dead cycle with no grant, so there is no back-to-back overlap on the resource. Then go IDLE; arbitration resumes in IDLE on the next edge.
- Winner selection:
  - RR_MODE=0: lowest set index of elig.
  - RR_MODE=1: first set bit of elig searching upward from rr_ptr with wrap-around N-1 -> 0.
  - rr_ptr is updated to (w+1) mod N at each grant issue.
- Mask:
  - mask[i] clears on any cycle where req[i]=0.
  - A timed-out requester cannot regain the grant until it drops req for at least one cycle.
  - Clearing mask[i] and setting mask[i] in the same cycle: set wins (only one can apply, since setting requires req[i]=1).
- A requester other than w changing req during BUSY has no effect on the grant.
- Grant ends only by release, timeout or reset; there is no preemption.
- All-zero elig in IDLE: remain in IDLE; gnt_code=0, never X.
- Reset mid-grant: outputs clear immediately (async); mask and rr_ptr clear.
- Invariants:
  - gnt is one-hot or zero.
  - gnt_valid == |gnt.
  - gnt_code is consistent with gnt.
  - timeout is never high two consecutive cycles.

Test Plan:
- Fixed priority: RR_MODE=0, req=8'b1010_0100 held -> gnt=8'b0000_0100, gnt_code=2 one cycle later. Drop req[2] -> GAP cycle with gnt=0, then gnt_code=5.
- Round-robin fairness: RR_MODE=1, req=8'hFF, each winner drops req for 1 cycle after 3 cycles of grant -> grant order 0,1,2,...,7,0, with one GAP cycle between grants.
- Timeout: MAX_HOLD=4, req=8'h01 held -> gnt valid for exactly 4 cycles, timeout pulses 1 cycle, then no regrant while req[0] stays high. Drop req[0] for 1 cycle and reassert -> grant again.
- Masked requester with competitor: MAX_HOLD=4, req=8'h03 held, RR_MODE=0 -> requester 0 times out; requester 1 is granted after GAP and IDLE.
- Wrap-around: RR_MODE=1, rr_ptr=7 after granting 6, req=8'h41 -> winner 0 (not 6).
- Async reset: assert rst_n=0 mid-BUSY between clock edges -> gnt, gnt_valid, gnt_code and timeout go 0 without a clock edge. After release with req=8'h80 -> gnt_code=7 one cycle later.

Source files
------------

// File: rtl/req_priority_arbiter.sv
// rtl/req_priority_arbiter.sv - N-way request arbiter with fixed/round-robin selection and hold timeout
module req_priority_arbiter #(
    parameter int N        = 8,
    parameter int CW       = 3,
    parameter int RR_MODE  = 0,
    parameter int MAX_HOLD = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  req,
    output logic [N-1:0]  gnt,
    output logic [CW-1:0] gnt_code,
    output logic          gnt_valid,
    output logic          timeout
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t        r_state;
    logic [7:0]    r_hold_cnt;
    logic [N-1:0]  r_mask;
    logic [CW-1:0] r_rr_ptr;
    logic [N-1:0]  r_gnt;
    logic [CW-1:0] r_gnt_code;
    logic          r_gnt_valid;
    logic          r_timeout;

    state_t        w_state_nxt;
    logic [7:0]    w_hold_nxt;
    logic [N-1:0]  w_mask_set;
    logic [CW-1:0] w_ptr_nxt;
    logic [N-1:0]  w_gnt_nxt;
    logic [CW-1:0] w_code_nxt;
    logic          w_valid_nxt;
    logic          w_tmo_nxt;

    logic [N-1:0]  w_elig;
    logic [N-1:0]  w_rot;
    logic [CW-1:0] w_base;
    logic [CW-1:0] w_off;
    logic [CW-1:0] w_win;
    logic          w_any;

    assign w_elig = req & ~r_mask;
    assign w_base = (RR_MODE != 0) ? r_rr_ptr : '0;
    assign w_any  = |w_elig;

    // Rotate eligibility so the search always starts at bit 0; wrap comes free from CW-bit index math.
    always_comb begin
        w_rot = '0;
        w_off = '0;
        for (int i = 0; i < N; i++) begin
            w_rot[i] = w_elig[w_base + CW'(i)];
        end
        for (int i = N - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_off = CW'(i);
            end
        end
    end

    assign w_win = w_base + w_off;

    always_comb begin
        w_state_nxt = r_state;
        w_hold_nxt  = r_hold_cnt;
        w_mask_set  = '0;
        w_ptr_nxt   = r_rr_ptr;
        w_gnt_nxt   = r_gnt;
        w_code_nxt  = r_gnt_code;
        w_valid_nxt = r_gnt_valid;
        w_tmo_nxt   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_gnt_nxt   = '0;
                w_code_nxt  = '0;
                w_valid_nxt = 1'b0;
                if (w_any) begin
                    w_gnt_nxt   = N'(1) << w_win;
                    w_code_nxt  = w_win;
                    w_valid_nxt = 1'b1;
                    w_hold_nxt  = 8'd1;
                    w_ptr_nxt   = w_win + CW'(1);
                    w_state_nxt = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (!req[r_gnt_code]) begin
                    w_gnt_nxt   = '0;
                    w_code_nxt  = '0;
                    w_valid_nxt = 1'b0;
                    w_hold_nxt  = '0;
                    w_state_nxt = ST_GAP;
                end else if (r_hold_cnt == 8'(MAX_HOLD)) begin
                    w_gnt_nxt   = '0;
                    w_code_nxt  = '0;
                    w_valid_nxt = 1'b0;
                    w_hold_nxt  = '0;
                    w_mask_set  = N'(1) << r_gnt_code;
                    w_tmo_nxt   = 1'b1;
                    w_state_nxt = ST_GAP;
                end else begin
                    w_hold_nxt = r_hold_cnt + 8'd1;
                end
            end
            ST_GAP: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_gnt_nxt   = '0;
                w_code_nxt  = '0;
                w_valid_nxt = 1'b0;
                w_hold_nxt  = '0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_hold_cnt  <= '0;
            r_mask      <= '0;
            r_rr_ptr    <= '0;
            r_gnt       <= '0;
            r_gnt_code  <= '0;
            r_gnt_valid <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_hold_cnt  <= w_hold_nxt;
            // A dropped request unmasks; a same-cycle timeout set still wins.
            r_mask      <= (r_mask & req) | w_mask_set;
            r_rr_ptr    <= w_ptr_nxt;
            r_gnt       <= w_gnt_nxt;
            r_gnt_code  <= w_code_nxt;
            r_gnt_valid <= w_valid_nxt;
            r_timeout   <= w_tmo_nxt;
        end
    end

    assign gnt       = r_gnt;
    assign gnt_code  = r_gnt_code;
    assign gnt_valid = r_gnt_valid;
    assign timeout   = r_timeout;

endmodule

// File: tb/tb_req_priority_arbiter.sv
// tb/tb_req_priority_arbiter.sv - scoreboard bench for req_priority_arbiter (fixed-priority and round-robin)
module tb_req_priority_arbiter;

    localparam int N  = 8;
    localparam int CW = 3;
    localparam int MH = 4;

    logic          clk;
    logic          rst_n;
    logic [N-1:0]  req;
    logic [N-1:0]  gnt_fp, gnt_rr;
    logic [CW-1:0] code_fp, code_rr;
    logic          valid_fp, valid_rr;
    logic          tmo_fp, tmo_rr;

    req_priority_arbiter #(.N(N), .CW(CW), .RR_MODE(0), .MAX_HOLD(MH)) u_fp (
        .clk(clk), .rst_n(rst_n), .req(req),
        .gnt(gnt_fp), .gnt_code(code_fp), .gnt_valid(valid_fp), .timeout(tmo_fp)
    );

    req_priority_arbiter #(.N(N), .CW(CW), .RR_MODE(1), .MAX_HOLD(MH)) u_rr (
        .clk(clk), .rst_n(rst_n), .req(req),
        .gnt(gnt_rr), .gnt_code(code_rr), .gnt_valid(valid_rr), .timeout(tmo_rr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0]  gnt;
        logic [CW-1:0] code;
        logic          valid;
        logic          tmo;
    } exp_t;

    exp_t q_fp[$];
    exp_t q_rr[$];

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: phase 0 = free, 1 = owned, 2 = dead cycle after a grant
    int           m_phase[2];
    int           m_owner[2];
    int           m_held[2];
    int           m_ptr[2];
    logic [N-1:0] m_mask[2];

    logic log_en = 1'b0;
    int   order[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset(input int m);
        m_phase[m] = 0;
        m_owner[m] = 0;
        m_held[m]  = 0;
        m_ptr[m]   = 0;
        m_mask[m]  = '0;
    endtask

    task automatic push_exp(input int m, input exp_t e);
        if (m == 0) q_fp.push_back(e);
        else        q_rr.push_back(e);
    endtask

    task automatic model_step(input int m, input logic [N-1:0] r, input logic rl);
        exp_t         e;
        logic [N-1:0] nmask;
        logic [N-1:0] elig;
        int           base;
        int           w;
        bit           found;
        e.tmo = 1'b0;
        if (!rl) begin
            model_reset(m);
        end else begin
            nmask = m_mask[m] & r;
            if (m_phase[m] == 0) begin
                elig  = r & ~m_mask[m];
                base  = (m == 1) ? m_ptr[m] : 0;
                found = 0;
                w     = 0;
                for (int k = 0; k < N; k++) begin
                    if (!found && elig[(base + k) % N]) begin
                        found = 1;
                        w     = (base + k) % N;
                    end
                end
                if (found) begin
                    m_owner[m] = w;
                    m_held[m]  = 1;
                    m_ptr[m]   = (w + 1) % N;
                    m_phase[m] = 1;
                end
            end else if (m_phase[m] == 1) begin
                if (!r[m_owner[m]]) begin
                    m_phase[m] = 2;
                end else if (m_held[m] == MH) begin
                    nmask[m_owner[m]] = 1'b1;
                    e.tmo      = 1'b1;
                    m_phase[m] = 2;
                end else begin
                    m_held[m]++;
                end
            end else begin
                m_phase[m] = 0;
            end
            m_mask[m] = nmask;
        end
        e.valid = (m_phase[m] == 1);
        e.code  = e.valid ? CW'(m_owner[m]) : '0;
        e.gnt   = e.valid ? (N'(1) << m_owner[m]) : '0;
        push_exp(m, e);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(0, req, rst_n);
        model_step(1, req, rst_n);
    endtask

    task automatic drive(input logic [N-1:0] r, input int n);
        repeat (n) begin
            tick();
            #1 req = r;
        end
    endtask

    // Mid-cycle reset: outputs drop without an edge, so this cycle's expectation becomes all-zero.
    task automatic assert_rst_mid();
        exp_t z;
        z.gnt = '0; z.code = '0; z.valid = 1'b0; z.tmo = 1'b0;
        rst_n = 1'b0;
        q_fp.delete();
        q_rr.delete();
        model_reset(0);
        model_reset(1);
        push_exp(0, z);
        push_exp(1, z);
    endtask

    initial begin : monitor
        exp_t e;
        logic prev_v;
        prev_v = 1'b0;
        forever begin
            @(negedge clk);
            if (q_fp.size() > 0) begin
                e = q_fp.pop_front();
                chk("fp_gnt",   32'(gnt_fp),   32'(e.gnt));
                chk("fp_code",  32'(code_fp),  32'(e.code));
                chk("fp_valid", 32'(valid_fp), 32'(e.valid));
                chk("fp_tmo",   32'(tmo_fp),   32'(e.tmo));
                chk("fp_onehot", 32'($onehot0(gnt_fp)), 32'd1);
            end
            if (q_rr.size() > 0) begin
                e = q_rr.pop_front();
                chk("rr_gnt",   32'(gnt_rr),   32'(e.gnt));
                chk("rr_code",  32'(code_rr),  32'(e.code));
                chk("rr_valid", 32'(valid_rr), 32'(e.valid));
                chk("rr_tmo",   32'(tmo_rr),   32'(e.tmo));
                chk("rr_vld_or", 32'(valid_rr), 32'(|gnt_rr));
            end
            if (log_en && valid_rr && !prev_v) order.push_back(int'(code_rr));
            prev_v = valid_rr;
        end
    end

    initial begin : stimulus
        logic [N-1:0] r;
        rst_n = 1'b0;
        req   = '0;
        model_reset(0);
        model_reset(1);

        drive('0, 3);
        tick();
        #1 rst_n = 1'b1;

        // Fixed priority pick, release, dead cycle, next winner
        drive(8'hA4, 3);
        drive(8'hA0, 6);
        drive(8'h00, 3);

        // Timeout with lone requester, masked until it drops
        drive(8'h01, 12);
        drive(8'h00, 1);
        drive(8'h01, 4);
        drive(8'h00, 3);

        // Timed-out requester yields to competitor
        drive(8'h03, 14);
        drive(8'h00, 3);

        // Round-robin wrap: grant 6 leaves pointer at 7
        drive(8'h40, 3);
        drive(8'h00, 3);
        drive(8'h41, 3);
        drive(8'h00, 3);

        // Async reset mid-grant
        drive(8'hFF, 3);
        tick();
        #3 assert_rst_mid();
        req = 8'h80;
        #1;
        chk("async_gnt_fp",   32'(gnt_fp),   32'd0);
        chk("async_code_fp",  32'(code_fp),  32'd0);
        chk("async_valid_fp", 32'(valid_fp), 32'd0);
        chk("async_tmo_fp",   32'(tmo_fp),   32'd0);
        chk("async_gnt_rr",   32'(gnt_rr),   32'd0);
        chk("async_code_rr",  32'(code_rr),  32'd0);
        chk("async_valid_rr", 32'(valid_rr), 32'd0);
        drive(8'h80, 2);
        tick();
        #1 rst_n = 1'b1;
        drive(8'h80, 3);
        drive(8'h00, 3);

        // Round-robin fairness from a clean pointer
        tick();
        #1 assert_rst_mid();
        tick();
        #1 rst_n = 1'b1;
        req    = 8'hFF;
        log_en = 1'b1;
        repeat (60) begin
            tick();
            r = 8'hFF;
            if (m_phase[1] == 1 && m_held[1] == 3) r[m_owner[1]] = 1'b0;
            #1 req = r;
        end
        @(negedge clk);
        log_en = 1'b0;
        chk("rr_order_len", 32'(order.size() >= 9), 32'd1);
        for (int i = 0; i < 9; i++) begin
            if (i < order.size()) chk("rr_order", 32'(order[i]), 32'(i % N));
        end

        // Random sticky requests
        r = '0;
        repeat (500) begin
            r = r ^ N'($urandom & $urandom);
            drive(r, 1);
        end
        drive('0, 4);

        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
